mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the main control decoder. It holds the PC and fetches each instruction word from instruction memory over a req/ack handshake. It presents the instruction, and its opcode field, to the decoder and datapath for exactly one execute window. It then computes the next PC from the decoder's Jump/Branch outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 2'b00.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals pc while imem_req=1
imem_ack  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction register
opcode  out  6  instr[31:26], drives control decoder opcode
pc_out  out  32  address of current instruction
pc_plus4  out  32  pc_out + 4
instr_valid  out  1  execute window active; decoder outputs and zero are consumed this cycle
Jump  in  1  from decoder
Branch  in  1  from decoder
zero  in  1  ALU zero flag
stall  in  1  hold current instruction in execute window
halt  in  1  stop fetching after the current instruction
retired_count  out  32  number of instructions completed

Behaviour:
- Reset (rst=1 at clk edge), which overrides everything:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_count=0.
  - A reset asserted mid-fetch drops imem_req on the next cycle. Any later ack from that fetch is ignored.
- FSM states: IDLE, FETCH, EXEC, HALTED.
- IDLE:
  - Outputs imem_req=0 for one cycle, then the FSM goes to FETCH.
- FETCH:
  - Drives imem_req=1 and imem_addr=pc, both stable until ack.
  - On imem_ack=1: instr<=imem_rdata, go to EXEC. Ack is allowed in the first FETCH cycle, so minimum latency is 1 cycle.
  - imem_ack in any state other than FETCH is ignored.
- EXEC:
  - instr_valid=1 and imem_req=0.
  - If stall=1: stay in EXEC. pc, instr and retired_count are unchanged and instr_valid stays 1.
  - If stall=0: update pc with the next-PC value below and increment retired_count by 1. Go to HALTED if halt=1, else to FETCH.
  - stall has priority over halt. halt is sampled only in a non-stalled EXEC cycle.
- Next-PC, combinational from the current instr and pc; Jump has priority:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else Branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
  - else: pc_plus4.
- HALTED:
  - imem_req=0 and instr_valid=0. pc holds the next-PC value that was computed.
  - The FSM stays here until rst.
- Arithmetic and width rules:
  - All PC arithmetic is 32-bit and wraps: pc 32'hFFFF_FFFC gives pc_plus4 = 0.
  - retired_count wraps from 32'hFFFF_FFFF to 0.
- Throughput: with single-cycle ack and no stall, one instruction per 2 cycles.
- Output conditions:
  - opcode is always instr[31:26]. In FETCH and HALTED it reflects the previous instruction, and consumers must qualify it with instr_valid.
  - Jump, Branch and zero are don't-care when instr_valid=0.
  - x values on Jump, Branch or zero must not corrupt pc outside EXEC.

Test Plan:
- Reset then ack in 1 cycle with rdata=32'h0000_0020 → imem_addr=0, instr_valid high in cycle 3, pc becomes 4, retired_count=1.
- At pc=32'h0000_0010, instr=32'h1000_FFFF, Branch=1, zero=1 → pc=32'h0000_0010; with zero=0 → pc=32'h0000_0014.
- At pc=32'h4000_0000, instr=32'h0800_0100, Jump=1, Branch=1, zero=1 → pc=32'h4000_0400 (Jump wins).
- Ack delayed 5 cycles, and stall held 3 cycles in EXEC → imem_addr stable, instr_valid high 4 cycles, retired_count +1 only.
- Reset asserted during FETCH, then a stale ack arrives → pc=RESET_PC, instr=0, stale ack ignored, new fetch from RESET_PC.
- halt=1 in EXEC at pc=32'hFFFF_FFFC, no jump or branch → pc=0, state HALTED, imem_req stays 0 for 20 cycles.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake, presents the
// instruction for one execute window, then advances the PC from Jump/Branch/zero.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        zero,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] retired_count,
    output logic [1:0]  dbg_state
);

    // Handshake: imem_req rises in FETCH and holds imem_addr steady until the first
    // cycle with imem_ack=1, which transfers imem_rdata; ack outside FETCH is ignored.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        req_q, valid_q;
    logic [31:0] next_pc;
    logic [31:0] branch_off;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // Jump/Branch/zero only reach pc_d in an unstalled EXEC cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = halt ? S_HALTED : S_FETCH;
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            req_q     <= (state_d == S_FETCH);
            valid_q   <= (state_d == S_EXEC);
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign opcode        = instr_q[31:26];
    assign pc_out        = pc_q;
    assign instr_valid   = valid_q;
    assign retired_count = retired_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: memory driver, reference PC model,
// and a queue of expected instruction words checked in each execute window.
module tb_mips_fetch_unit;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        zero = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] retired_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_retired;

    mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid),
        .Jump(Jump), .Branch(Branch), .zero(zero),
        .stall(stall), .halt(halt),
        .retired_count(retired_count),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] iw,
                                                 input logic j, input logic b, input logic z);
        logic [31:0] pcp4;
        logic [31:0] off;
        pcp4 = pc + 32'd4;
        off  = {{16{iw[15]}}, iw[15:0]};
        if (j)           return {pcp4[31:28], iw[25:0], 2'b00};
        else if (b && z) return pcp4 + (off << 2);
        else             return pcp4;
    endfunction

    // Driver: serve one fetch, run the execute window, retire the instruction.
    task automatic do_instr(input logic [31:0] rdata, input int ack_delay, input int stall_cycles,
                            input logic j, input logic b, input logic z, input logic h,
                            output int req_wait);
        logic [31:0] exp_iw;
        logic [31:0] nxt;
        req_wait = 0;
        while (!imem_req) begin
            if (req_wait >= 20) begin
                check("req_timeout", 32'd0, 32'd1);
                finish_run();
            end
            step();
            req_wait++;
        end
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < ack_delay; i++) begin
            step();
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_held", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_q.push_back(rdata);
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("valid_exec", {31'd0, instr_valid}, 32'd1);
        check("req_exec", {31'd0, imem_req}, 32'd0);
        exp_iw = exp_q.pop_front();
        check("instr", instr, exp_iw);
        check("opcode", {26'd0, opcode}, {26'd0, exp_iw[31:26]});
        check("pc_out", pc_out, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        for (int i = 0; i < stall_cycles; i++) begin
            stall  = 1'b1;
            halt   = 1'b1;
            Jump   = 1'($urandom_range(0, 1));
            Branch = 1'($urandom_range(0, 1));
            zero   = 1'($urandom_range(0, 1));
            step();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", pc_out, m_pc);
            check("stall_instr", instr, exp_iw);
            check("stall_retired", retired_count, m_retired);
        end
        stall  = 1'b0;
        Jump   = j;
        Branch = b;
        zero   = z;
        halt   = h;
        nxt    = model_next_pc(m_pc, exp_iw, j, b, z);
        step();
        Jump = 1'b0; Branch = 1'b0; zero = 1'b0; halt = 1'b0;
        m_pc      = nxt;
        m_retired = m_retired + 32'd1;
        check("next_pc", pc_out, m_pc);
        check("retired", retired_count, m_retired);
        check("valid_after", {31'd0, instr_valid}, 32'd0);
        if (h) check("state_halted", {30'd0, dbg_state}, {30'd0, ST_HALTED});
        else   check("req_after", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        int w;
        logic [31:0] iw;
        logic j, b, z;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        rst = 1'b0;
        m_pc = 32'd0;
        m_retired = 32'd0;

        // First fetch: one IDLE cycle, single-cycle ack
        do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, w);
        check("idle_cycles", w, 32'd1);
        check("pc_first", pc_out, 32'h0000_0004);

        // Branch to 0x10, self-branch taken, then not taken
        do_instr(32'h1000_0002, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, w);
        check("pc_at_10", pc_out, 32'h0000_0010);
        check("back2back", w, 32'd0);
        do_instr(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, w);
        check("br_taken", pc_out, 32'h0000_0010);
        do_instr(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, w);
        check("br_not_taken", pc_out, 32'h0000_0014);

        // Slow ack plus stall (halt held during stall must be ignored)
        do_instr(32'h0123_4567, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0, w);

        // Random traffic with branch offsets kept forward so pc stays low
        for (int n = 0; n < 10; n++) begin
            iw = $urandom;
            j  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            if (b && z && !j) iw[15] = 1'b0;
            do_instr(iw, $urandom_range(0, 3), $urandom_range(0, 2), j, b, z, 1'b0, w);
        end

        // Reset during FETCH, then a stale ack while IDLE
        for (int i = 0; i < 2; i++) begin
            check("pre_rst_fetch", {31'd0, imem_req}, 32'd1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_pc", pc_out, 32'd0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_retired", retired_count, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("stale_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
        check("stale_instr", instr, 32'd0);
        m_pc = 32'd0;
        m_retired = 32'd0;
        do_instr(32'h2222_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, w);

        // Jump beats a taken branch
        do_instr(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, w);
        check("jump_wins", pc_out, 32'h0000_0400);

        // Backward branch wraps to the top of the address space
        do_instr(32'h1000_FEFE, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, w);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0000_0000);

        // Halt at the last word: pc wraps to 0, then nothing else happens
        do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, w);
        check("halt_pc", pc_out, 32'd0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            Jump = 1'($urandom_range(0, 1));
            Branch = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            step();
            check("halted_req", {31'd0, imem_req}, 32'd0);
            check("halted_valid", {31'd0, instr_valid}, 32'd0);
            check("halted_pc", pc_out, 32'd0);
            check("halted_retired", retired_count, m_retired);
        end
        imem_ack = 1'b0;
        check("exp_q_empty", exp_q.size(), 32'd0);
        finish_run();
    end

endmodule
